// File: rtl/ysyx_22041071_axi_w_master_pkg.sv
// Shared AXI4 constants for the write-channel initiator: default bus widths,
// AxBURST encodings and xRESP codes.
// Imported by ysyx_22041071_axi_w_master; holds no logic.
package ysyx_22041071_axi_w_master_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22041071_axi_w_master.sv
// AXI4 write initiator (AW/W/B) for the CPU core: one request in, its beats streamed on W, its B response returned.
// Latency: request accepted in cycle N drives axi_aw_valid in N+1; W is a combinational pass-through; cpu_b_valid one cycle after the B handshake.
// Backpressure: AW payload is held until axi_aw_ready; cpu_w_ready follows axi_w_ready; only one outstanding transaction.
// Ports: cpu_aw_* request in, cpu_w_* beats in, cpu_b_* completion pulse out;
//        axi_aw_* / axi_w_* / axi_b_* are the AXI4 write channels toward the crossbar.
module ysyx_22041071_axi_w_master
    import ysyx_22041071_axi_w_master_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    // CPU request
    input  logic                cpu_aw_valid,
    output logic                cpu_aw_ready,
    input  logic [ID_W-1:0]     cpu_id,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [LEN_W-1:0]    cpu_len,
    input  logic [1:0]          cpu_size,
    // CPU write beats
    input  logic                cpu_w_valid,
    output logic                cpu_w_ready,
    input  logic [DATA_W-1:0]   cpu_w_data,
    input  logic [DATA_W/8-1:0] cpu_w_strb,
    // CPU completion
    output logic                cpu_b_valid,
    output logic [1:0]          cpu_b_resp,
    output logic [ID_W-1:0]     cpu_b_id,
    // AXI AW
    output logic                axi_aw_valid,
    input  logic                axi_aw_ready,
    output logic [ID_W-1:0]     axi_aw_id,
    output logic [ADDR_W-1:0]   axi_aw_addr,
    output logic [LEN_W-1:0]    axi_aw_len,
    output logic [2:0]          axi_aw_size,
    output logic [1:0]          axi_aw_burst,
    output logic [2:0]          axi_aw_prot,
    output logic                axi_aw_lock,
    output logic [3:0]          axi_aw_cache,
    output logic [3:0]          axi_aw_qos,
    output logic [3:0]          axi_aw_region,
    output logic                axi_aw_user,
    // AXI W
    output logic                axi_w_valid,
    input  logic                axi_w_ready,
    output logic [DATA_W-1:0]   axi_w_data,
    output logic [DATA_W/8-1:0] axi_w_strb,
    output logic                axi_w_last,
    // AXI B
    input  logic                axi_b_valid,
    output logic                axi_b_ready,
    input  logic [1:0]          axi_b_resp,
    input  logic [ID_W-1:0]     axi_b_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e              state_q;
    logic [ID_W-1:0]     aw_id_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [LEN_W-1:0]    aw_len_q;
    logic [2:0]          aw_size_q;
    logic [1:0]          aw_burst_q;
    logic [LEN_W-1:0]    beat_cnt_q;
    logic                b_vld_q;
    logic [1:0]          b_resp_q;
    logic [ID_W-1:0]     b_id_q;

    logic in_data;
    logic w_hs;
    logic w_last;

    assign in_data = (state_q == S_DATA);
    assign w_last  = in_data && (beat_cnt_q == aw_len_q);
    assign w_hs    = in_data && cpu_w_valid && axi_w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            beat_cnt_q <= '0;
            b_vld_q    <= 1'b0;
            b_resp_q   <= '0;
            b_id_q     <= '0;
        end else begin
            // completion is a single-cycle pulse
            b_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_aw_valid) begin
                        aw_id_q    <= cpu_id;
                        // bus-aligned address: the CPU already lane-aligns data and strobes
                        aw_addr_q  <= cpu_addr & ~ADDR_W'(7);
                        aw_len_q   <= cpu_len;
                        aw_size_q  <= {1'b0, cpu_size};
                        aw_burst_q <= BURST_INCR;
                        state_q    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi_aw_ready) begin
                        beat_cnt_q <= '0;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        if (w_last) begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (axi_b_valid) begin
                        b_resp_q <= axi_b_resp;
                        b_id_q   <= axi_b_id;
                        b_vld_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Held off while reset is asserted so no request is taken during reset.
    assign cpu_aw_ready  = (state_q == S_IDLE) && !reset;

    assign axi_aw_valid  = (state_q == S_ADDR);
    assign axi_aw_id     = aw_id_q;
    assign axi_aw_addr   = aw_addr_q;
    assign axi_aw_len    = aw_len_q;
    assign axi_aw_size   = aw_size_q;
    assign axi_aw_burst  = aw_burst_q;
    assign axi_aw_prot   = 3'b000;
    assign axi_aw_lock   = 1'b0;
    assign axi_aw_cache  = 4'b0000;
    assign axi_aw_qos    = 4'b0000;
    assign axi_aw_region = 4'b0000;
    assign axi_aw_user   = 1'b0;

    // W pass-through, gated so nothing leaks onto the bus before the AW handshake.
    assign axi_w_valid   = in_data && cpu_w_valid;
    assign cpu_w_ready   = in_data && axi_w_ready;
    assign axi_w_data    = in_data ? cpu_w_data : '0;
    assign axi_w_strb    = in_data ? cpu_w_strb : '0;
    assign axi_w_last    = w_last;

    assign axi_b_ready   = (state_q == S_RESP);
    assign cpu_b_valid   = b_vld_q;
    assign cpu_b_resp    = b_resp_q;
    assign cpu_b_id      = b_id_q;

endmodule
